// File: rtl/intr_src.sv
// intr_src: source side of a cross-domain interrupt link.
//   Coalesces one-cycle event pulses into a registered level interrupt and runs a
//   4-phase req/ack handshake against an asynchronous acknowledge.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   en        in   1 = accept event pulses, 0 = drop new events
//   evt_pulse in   one-cycle event strobe
//   intr      out  interrupt level to the remote domain (direct flop output)
//   intr_ack  in   asynchronous acknowledge from the remote domain
//   busy      out  handshake in flight
//   pend_cnt  out  events accepted but not yet carried by an interrupt
//   sent_cnt  out  events carried by the current or last interrupt
module intr_src #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_ASSERT  = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             evt_pulse,
   output logic             intr,
   input  logic             intr_ack,
   output logic             busy,
   output logic [CNT_W-1:0] pend_cnt,
   output logic [CNT_W-1:0] sent_cnt
);

   localparam int unsigned HOLD_W = (MIN_ASSERT > 1) ? $clog2(MIN_ASSERT) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   // One-hot states; bit 1 is the interrupt level, bit 0 marks idle.
   typedef enum logic [2:0] {
      S_IDLE    = 3'b001,
      S_ASSERT  = 3'b010,
      S_RELEASE = 3'b100
   } state_t;

   state_t                 r_state;
   logic [HOLD_W-1:0]      r_hold;
   logic [CNT_W-1:0]       r_pend;
   logic [CNT_W-1:0]       r_sent;
   logic [SYNC_STAGES-1:0] r_ack_sync;

   logic                   w_ack_s;
   logic                   w_acc;
   logic [CNT_W-1:0]       w_pend_inc;

   // Acknowledge synchronizer; the only consumer of raw intr_ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], intr_ack};
      end
   end

   assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
   assign w_acc      = evt_pulse & en;
   assign w_pend_inc = (r_pend == CNT_MAX) ? r_pend : r_pend + 1'b1;

   // Handshake FSM with event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
         r_pend  <= '0;
         r_sent  <= '0;
      end else begin
         r_pend <= w_acc ? w_pend_inc : r_pend;
         case (r_state)
            S_IDLE: begin
               if ((r_pend != '0) && !w_ack_s) begin
                  r_state <= S_ASSERT;
                  r_hold  <= '0;
                  r_sent  <= r_pend;
                  // A strobe in the capture cycle belongs to the next interrupt.
                  r_pend  <= w_acc ? CNT_W'(1) : '0;
               end
            end
            S_ASSERT: begin
               // Hold saturates at its last value, so equality means "minimum met".
               if (r_hold != HOLD_LAST) begin
                  r_hold <= r_hold + 1'b1;
               end
               if ((r_hold == HOLD_LAST) && w_ack_s) begin
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!w_ack_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign intr     = r_state[1];
   assign busy     = ~r_state[0];
   assign pend_cnt = r_pend;
   assign sent_cnt = r_sent;

endmodule

// File: tb/tb_intr_src.sv
// tb_intr_src: self-checking bench for intr_src (SYNC_STAGES=2, MIN_ASSERT=4, CNT_W=8).
// Expected sent_cnt values are queued when events are driven and popped when an
// interrupt rises.
module tb_intr_src;

   logic       clk;
   logic       rst;
   logic       en;
   logic       evt_pulse;
   logic       intr;
   logic       intr_ack;
   logic       busy;
   logic [7:0] pend_cnt;
   logic [7:0] sent_cnt;

   int n_cmp;
   int n_err;
   int exp_q[$];

   intr_src #(.SYNC_STAGES(2), .MIN_ASSERT(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .evt_pulse (evt_pulse),
      .intr      (intr),
      .intr_ack  (intr_ack),
      .busy      (busy),
      .pend_cnt  (pend_cnt),
      .sent_cnt  (sent_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int sb_pop();
      if (exp_q.size() == 0) return -1;
      return exp_q.pop_front();
   endfunction

   // Waits (at negedges) for intr (sel_busy=0) or busy (sel_busy=1) to reach val.
   task automatic wait_lvl(input bit sel_busy, input logic val, input int max_cyc,
                           output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if ((sel_busy ? busy : intr) === val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Full acknowledge cycle: raise ack, wait intr low, drop ack, wait idle.
   task automatic do_hs(output bit ok);
      bit a, b;
      intr_ack = 1'b1;
      wait_lvl(1'b0, 1'b0, 20, a);
      intr_ack = 1'b0;
      wait_lvl(1'b1, 1'b0, 20, b);
      ok = a & b;
   endtask

   task automatic pulse_n(input int n);
      for (int i = 0; i < n; i++) begin
         evt_pulse = 1'b1;
         @(negedge clk);
         evt_pulse = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; intr_ack = 1'b1; en = 1'b1; evt_pulse = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         evt_pulse = ~evt_pulse;
      end
      @(negedge clk);
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL reset_intr: got %b expected 0", intr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (pend_cnt !== 8'd0) begin n_err++; $display("FAIL reset_pend: got %0d expected 0", pend_cnt); end
      n_cmp++; if (sent_cnt !== 8'd0) begin n_err++; $display("FAIL reset_sent: got %0d expected 0", sent_cnt); end
      evt_pulse = 1'b0; intr_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      int e;
      bit held;
      // cycle 0
      evt_pulse = 1'b1; exp_q.push_back(1);
      @(negedge clk); // cycle 1
      evt_pulse = 1'b0;
      n_cmp++; if (pend_cnt !== 8'd1) begin n_err++; $display("FAIL single_pend_c1: got %0d expected 1", pend_cnt); end
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL single_intr_c1: got %b expected 0", intr); end
      @(negedge clk); // cycle 2
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL single_intr_c2: got %b expected 1", intr); end
      e = sb_pop();
      n_cmp++; if ({24'd0, sent_cnt} !== e) begin n_err++; $display("FAIL single_sent: got %0d expected %0d", sent_cnt, e); end
      n_cmp++; if (pend_cnt !== 8'd0) begin n_err++; $display("FAIL single_pend_c2: got %0d expected 0", pend_cnt); end
      @(negedge clk); // cycle 3
      intr_ack = 1'b1;
      held = (intr === 1'b1);
      @(negedge clk); // cycle 4
      held = held & (intr === 1'b1);
      @(negedge clk); // cycle 5
      held = held & (intr === 1'b1);
      n_cmp++; if (!held) begin n_err++; $display("FAIL single_min_hold: got intr low in cycles 3..5 expected high"); end
      @(negedge clk); // cycle 6
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL single_intr_fall_c6: got %b expected 0", intr); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_release: got %b expected 1", busy); end
      intr_ack = 1'b0;
      @(negedge clk); // cycle 7
      @(negedge clk); // cycle 8
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_c8: got %b expected 1", busy); end
      @(negedge clk); // cycle 9
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_c9: got %b expected 0", busy); end
      @(negedge clk);
   endtask

   task automatic test_coalesce();
      int e;
      bit ok;
      evt_pulse = 1'b1; exp_q.push_back(1);
      @(negedge clk);
      evt_pulse = 1'b0;
      @(negedge clk);
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL coal_first_rise: got %b expected 1", intr); end
      e = sb_pop();
      n_cmp++; if ({24'd0, sent_cnt} !== e) begin n_err++; $display("FAIL coal_first_sent: got %0d expected %0d", sent_cnt, e); end
      pulse_n(5); exp_q.push_back(5);
      n_cmp++; if (pend_cnt !== 8'd5) begin n_err++; $display("FAIL coal_pend: got %0d expected 5", pend_cnt); end
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL coal_wait_assert: got %b expected 1", intr); end
      do_hs(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL coal_hs1: got timeout expected completion"); end
      wait_lvl(1'b0, 1'b1, 10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL coal_second_rise: got timeout expected intr=1"); end
      e = sb_pop();
      n_cmp++; if ({24'd0, sent_cnt} !== e) begin n_err++; $display("FAIL coal_second_sent: got %0d expected %0d", sent_cnt, e); end
      n_cmp++; if (pend_cnt !== 8'd0) begin n_err++; $display("FAIL coal_second_pend: got %0d expected 0", pend_cnt); end
      do_hs(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL coal_hs2: got timeout expected completion"); end
   endtask

   task automatic test_collision();
      int e;
      bit ok;
      evt_pulse = 1'b1; exp_q.push_back(1);
      @(negedge clk);
      evt_pulse = 1'b0;
      wait_lvl(1'b0, 1'b1, 10, ok);
      e = sb_pop();
      n_cmp++; if (!ok || ({24'd0, sent_cnt} !== e)) begin n_err++; $display("FAIL coll_first: got ok=%0d sent=%0d expected sent %0d", ok, sent_cnt, e); end
      intr_ack = 1'b1;
      wait_lvl(1'b0, 1'b0, 20, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL coll_release: got timeout expected intr=0"); end
      evt_pulse = 1'b1; @(negedge clk); evt_pulse = 1'b0; @(negedge clk);
      evt_pulse = 1'b1; @(negedge clk); evt_pulse = 1'b0;
      n_cmp++; if (pend_cnt !== 8'd2) begin n_err++; $display("FAIL coll_pend_before: got %0d expected 2", pend_cnt); end
      intr_ack = 1'b0;
      wait_lvl(1'b1, 1'b0, 10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL coll_idle: got timeout expected busy=0"); end
      // Strobe lands in the IDLE->ASSERT capture cycle.
      evt_pulse = 1'b1; exp_q.push_back(2); exp_q.push_back(1);
      @(negedge clk);
      evt_pulse = 1'b0;
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL coll_rise: got %b expected 1", intr); end
      e = sb_pop();
      n_cmp++; if ({24'd0, sent_cnt} !== e) begin n_err++; $display("FAIL coll_sent: got %0d expected %0d", sent_cnt, e); end
      n_cmp++; if (pend_cnt !== 8'd1) begin n_err++; $display("FAIL coll_pend_after: got %0d expected 1", pend_cnt); end
      do_hs(ok);
      wait_lvl(1'b0, 1'b1, 10, ok);
      e = sb_pop();
      n_cmp++; if (!ok || ({24'd0, sent_cnt} !== e)) begin n_err++; $display("FAIL coll_next: got ok=%0d sent=%0d expected sent %0d", ok, sent_cnt, e); end
      do_hs(ok);
   endtask

   task automatic test_saturate();
      int e;
      bit ok;
      evt_pulse = 1'b1; exp_q.push_back(1);
      @(negedge clk);
      evt_pulse = 1'b0;
      wait_lvl(1'b0, 1'b1, 10, ok);
      e = sb_pop();
      n_cmp++; if (!ok || ({24'd0, sent_cnt} !== e)) begin n_err++; $display("FAIL sat_first: got ok=%0d sent=%0d expected sent %0d", ok, sent_cnt, e); end
      pulse_n(300);
      n_cmp++; if (pend_cnt !== 8'd255) begin n_err++; $display("FAIL sat_pend: got %0d expected 255", pend_cnt); end
      en = 1'b0;
      pulse_n(10);
      n_cmp++; if (pend_cnt !== 8'd255) begin n_err++; $display("FAIL sat_en0_pend: got %0d expected 255", pend_cnt); end
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL sat_no_timeout: got %b expected 1", intr); end
      exp_q.push_back(255);
      do_hs(ok);
      wait_lvl(1'b0, 1'b1, 10, ok);
      e = sb_pop();
      n_cmp++; if (!ok || ({24'd0, sent_cnt} !== e)) begin n_err++; $display("FAIL sat_deliver_en0: got ok=%0d sent=%0d expected sent %0d", ok, sent_cnt, e); end
      do_hs(ok);
      en = 1'b1;
      n_cmp++; if (busy !== 1'b0 || pend_cnt !== 8'd0) begin n_err++; $display("FAIL sat_drained: got busy=%b pend=%0d expected 0/0", busy, pend_cnt); end
   endtask

   task automatic test_reset_mid();
      int e;
      bit ok;
      bit seen;
      evt_pulse = 1'b1;
      @(negedge clk);
      evt_pulse = 1'b0;
      wait_lvl(1'b0, 1'b1, 10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_rise: got timeout expected intr=1"); end
      pulse_n(3);
      rst = 1'b1;
      #1;
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL rmid_intr_async: got %b expected 0", intr); end
      n_cmp++; if (busy !== 1'b0 || pend_cnt !== 8'd0) begin n_err++; $display("FAIL rmid_state: got busy=%b pend=%0d expected 0/0", busy, pend_cnt); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (intr !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen) begin n_err++; $display("FAIL rmid_no_spurious: got activity after reset expected none"); end
      n_cmp++; if (sent_cnt !== 8'd0) begin n_err++; $display("FAIL rmid_sent: got %0d expected 0", sent_cnt); end
      evt_pulse = 1'b1; exp_q.push_back(1);
      @(negedge clk);
      evt_pulse = 1'b0;
      wait_lvl(1'b0, 1'b1, 10, ok);
      e = sb_pop();
      n_cmp++; if (!ok || ({24'd0, sent_cnt} !== e)) begin n_err++; $display("FAIL rmid_new_event: got ok=%0d sent=%0d expected sent %0d", ok, sent_cnt, e); end
      do_hs(ok);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1; en = 1'b1; evt_pulse = 1'b0; intr_ack = 1'b0;
      test_reset();
      test_single();
      test_coalesce();
      test_collision();
      test_saturate();
      test_reset_mid();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
